// File: rtl/cellrv32_bus_responder.sv
// cellrv32_bus_responder: bus-window responder bridging single-cycle ack/err
// bus handshakes to a slow, multi-cycle device port.
// Optional feature: `define CELLRV32_BUS_RESPONDER_TIMEOUT_EN enables the
// internal response deadline (RESP_LIMIT); without it BUSY waits on dev_rdy_i.
module cellrv32_bus_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FE00,
  parameter int unsigned ADDR_BITS  = 6,
  parameter int unsigned RESP_LIMIT = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          addr_i,
  input  logic                 rden_i,
  input  logic                 wren_i,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o,
  output logic                 ack_o,
  output logic                 err_o,
  output logic                 dev_req_o,
  output logic                 dev_we_o,
  output logic [ADDR_BITS-1:0] dev_addr_o,
  output logic [31:0]          dev_wdata_o,
  input  logic [31:0]          dev_rdata_i,
  input  logic                 dev_rdy_i,
  input  logic                 dev_err_i
);

  if (RESP_LIMIT < 1) begin : g_bad_limit
    $error("cellrv32_bus_responder: RESP_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t                r_state;
  logic                  r_we;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [31:0]           r_wdata;
  logic                  r_req;
  logic                  r_ack;
  logic                  r_err;
  logic [31:0]           r_rdata;

  logic                  w_hit;
  logic                  w_accept;
  logic                  w_expired;

  assign w_hit    = (addr_i[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  assign w_accept = (rden_i | wren_i) & w_hit;

`ifdef CELLRV32_BUS_RESPONDER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(RESP_LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  assign w_expired = (r_cnt == '0);

  // deadline counter: loaded on acceptance, counts down only while nonzero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_accept) begin
      r_cnt <= CNT_W'(RESP_LIMIT - 1);
    end else if ((r_state == S_BUSY) && !dev_rdy_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end
`else
  assign w_expired = 1'b0;
`endif

  // access FSM; the response pulse and read data are registered on the
  // BUSY->RESP transition so they are visible exactly during RESP
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_req   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= wren_i;
            r_addr  <= addr_i[ADDR_BITS-1:0];
            r_wdata <= data_i;
            r_req   <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dev_rdy_i) begin
            r_req   <= 1'b0;
            r_ack   <= ~dev_err_i;
            r_err   <= dev_err_i;
            r_rdata <= (!r_we && !dev_err_i) ? dev_rdata_i : '0;
            r_state <= S_RESP;
          end else if (w_expired) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign data_o      = r_rdata;
  assign ack_o       = r_ack;
  assign err_o       = r_err;
  assign dev_req_o   = r_req;
  assign dev_we_o    = r_we;
  assign dev_addr_o  = r_addr;
  assign dev_wdata_o = r_wdata;

endmodule
